// File: rtl/mdu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mdu -- MIPS-style multiply/divide unit with HI/LO registers.
//
// Multiplies take 5 busy cycles; divides use restoring division on operand
// magnitudes and take DATA_W busy cycles, one quotient bit per cycle.
// mthi/mtlo write HI/LO in a single cycle. HI/LO keep their old values while
// an operation is in flight and are updated only on its completion edge.
//
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu
// (codes 7-10). Without it those codes are treated as nop.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   A      in   operand 1 (rs): dividend / multiplicand / mthi-mtlo source
//   B      in   operand 2 (rt): divisor / multiplier
//   MDUOp  in   operation code (0 nop,1 mult,2 multu,3 div,4 divu,5 mthi,
//               6 mtlo,7 madd,8 maddu,9 msub,10 msubu, others nop)
//   start  in   qualifies MDUOp for one cycle
//   HI     out  HI register
//   LO     out  LO register
//   busy   out  registered, high while a mult/div is in progress
//   stall  out  combinational: busy or a multi-cycle op being requested
// -----------------------------------------------------------------------------
module mdu #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [3:0]        MDUOp,
  input  logic              start,
  output logic [DATA_W-1:0] HI,
  output logic [DATA_W-1:0] LO,
  output logic              busy,
  output logic              stall
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] MUL_CYC = CNT_W'(5);
  localparam logic [CNT_W-1:0] DIV_CYC = CNT_W'(DATA_W);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;

  localparam logic [1:0] ACC_NONE = 2'd0;
  localparam logic [1:0] ACC_ADD  = 2'd1;
  localparam logic [1:0] ACC_SUB  = 2'd2;
`endif

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  // Two's-complement negate when neg is set.
  function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] v,
                                               input logic neg);
    return neg ? (~v + DATA_W'(1)) : v;
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              busy_nxt;
  logic              mul_done, div_done;

  logic              is_mul, is_div, op_sgn, accept;
`ifdef MDU_MADD_EN
  logic [1:0]        acc_d, acc_mode;
`endif

  // Latched operands: raw values for multiply, magnitudes for divide.
  // During DIV op_a doubles as the dividend/quotient shift register.
  logic [DATA_W-1:0] op_a, op_b, rem;
  logic              mul_sgn, q_neg, r_neg, dz;

  logic [2*DATA_W-1:0] ma, mb, prod, mul_res;
  logic [DATA_W:0]     div_shift, div_diff;
  logic [DATA_W-1:0]   rem_nxt, quo_nxt;

  // Opcode decode
  always_comb begin
    is_mul = 1'b0;
    is_div = 1'b0;
    op_sgn = 1'b0;
`ifdef MDU_MADD_EN
    acc_d  = ACC_NONE;
`endif
    case (MDUOp)
      OP_MULT:  begin is_mul = 1'b1; op_sgn = 1'b1; end
      OP_MULTU: is_mul = 1'b1;
      OP_DIV:   begin is_div = 1'b1; op_sgn = 1'b1; end
      OP_DIVU:  is_div = 1'b1;
`ifdef MDU_MADD_EN
      OP_MADD:  begin is_mul = 1'b1; op_sgn = 1'b1; acc_d = ACC_ADD; end
      OP_MADDU: begin is_mul = 1'b1; acc_d = ACC_ADD; end
      OP_MSUB:  begin is_mul = 1'b1; op_sgn = 1'b1; acc_d = ACC_SUB; end
      OP_MSUBU: begin is_mul = 1'b1; acc_d = ACC_SUB; end
`endif
      default: ;
    endcase
  end

  assign accept = start && (state == IDLE);
  assign stall  = busy | (start & (is_mul | is_div));

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
    end
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    busy_nxt  = busy;
    mul_done  = 1'b0;
    div_done  = 1'b0;
    case (state)
      IDLE: begin
        if (accept && is_mul) begin
          state_nxt = MUL;
          cnt_nxt   = MUL_CYC;
          busy_nxt  = 1'b1;
        end else if (accept && is_div) begin
          state_nxt = DIV;
          cnt_nxt   = DIV_CYC;
          busy_nxt  = 1'b1;
        end
      end
      MUL: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          mul_done  = 1'b1;
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      DIV: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          div_done  = 1'b1;
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // Product: sign/zero-extend to 2*DATA_W; the low 2*DATA_W bits of the
  // product are then correct for both signed and unsigned operands.
  always_comb begin
    ma   = {{DATA_W{mul_sgn & op_a[DATA_W-1]}}, op_a};
    mb   = {{DATA_W{mul_sgn & op_b[DATA_W-1]}}, op_b};
    prod = ma * mb;
`ifdef MDU_MADD_EN
    case (acc_mode)
      ACC_ADD: mul_res = {HI, LO} + prod;
      ACC_SUB: mul_res = {HI, LO} - prod;
      default: mul_res = prod;
    endcase
`else
    mul_res = prod;
`endif
  end

  // One restoring-division step; bit DATA_W of the difference is the borrow.
  always_comb begin
    div_shift = {rem, op_a[DATA_W-1]};
    div_diff  = div_shift - {1'b0, op_b};
    if (!div_diff[DATA_W]) begin
      rem_nxt = div_diff[DATA_W-1:0];
      quo_nxt = {op_a[DATA_W-2:0], 1'b1};
    end else begin
      rem_nxt = div_shift[DATA_W-1:0];
      quo_nxt = {op_a[DATA_W-2:0], 1'b0};
    end
  end

  // Datapath registers and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a     <= '0;
      op_b     <= '0;
      rem      <= '0;
      mul_sgn  <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dz       <= 1'b0;
`ifdef MDU_MADD_EN
      acc_mode <= ACC_NONE;
`endif
      HI       <= '0;
      LO       <= '0;
    end else begin
      if (accept && is_mul) begin
        op_a     <= A;
        op_b     <= B;
        mul_sgn  <= op_sgn;
`ifdef MDU_MADD_EN
        acc_mode <= acc_d;
`endif
      end
      if (accept && is_div) begin
        op_a  <= neg_if(A, op_sgn & A[DATA_W-1]);
        op_b  <= neg_if(B, op_sgn & B[DATA_W-1]);
        rem   <= '0;
        q_neg <= op_sgn & (A[DATA_W-1] ^ B[DATA_W-1]);
        r_neg <= op_sgn & A[DATA_W-1];
        dz    <= (B == '0);
      end
      if (state == DIV) begin
        op_a <= quo_nxt;
        rem  <= rem_nxt;
      end
      if (accept && (MDUOp == OP_MTHI)) HI <= A;
      if (accept && (MDUOp == OP_MTLO)) LO <= A;
      if (mul_done) {HI, LO} <= mul_res;
      // A zero divisor runs the full sequence but leaves HI/LO untouched.
      if (div_done && !dz) begin
        LO <= neg_if(quo_nxt, q_neg);
        HI <= neg_if(rem_nxt, r_neg);
      end
    end
  end

endmodule

// File: tb/tb_mdu.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_mdu -- directed self-checking bench for mdu.
// Covers reset, mult/multu, div/divu (incl. overflow and divide-by-zero),
// mthi/mtlo, ignored starts while busy and on the completion edge, reset
// mid-operation, and madd/msub (or their nop behaviour without MDU_MADD_EN).
// -----------------------------------------------------------------------------
module tb_mdu;

  logic        clk;
  logic        rst_n;
  logic [31:0] A, B;
  logic [3:0]  MDUOp;
  logic        start;
  logic [31:0] HI, LO;
  logic        busy, stall;

  int n_checks = 0;
  int n_errs   = 0;

  mdu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .MDUOp (MDUOp),
    .start (start),
    .HI    (HI),
    .LO    (LO),
    .busy  (busy),
    .stall (stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one start pulse; returns stall as seen during the request cycle.
  // Returns at the falling edge after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic stall_seen);
    @(negedge clk);
    MDUOp = op; A = a; B = b; start = 1'b1;
    #1 stall_seen = stall;
    @(negedge clk);
    start = 1'b0; MDUOp = 4'd0;
  endtask

  // Count busy cycles (bounded) and confirm HI/LO hold their old values.
  task automatic run_busy(input string tag, input int exp_cyc,
                          input logic [31:0] pre_hi, input logic [31:0] pre_lo);
    int  n = 0;
    bit  moved = 1'b0;
    while (busy === 1'b1 && n < 100) begin
      if (HI !== pre_hi || LO !== pre_lo) moved = 1'b1;
      n++;
      @(negedge clk);
    end
    check({tag, "_cycles"}, 64'(n), 64'(exp_cyc));
    check({tag, "_stable"}, 64'(moved), 64'd0);
  endtask

  logic st;

  initial begin
    rst_n = 1'b0; start = 1'b0; MDUOp = 4'd0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", HI, 0);
    check("rst_lo", LO, 0);
    check("rst_busy", busy, 0);
    check("rst_stall", stall, 0);
    rst_n = 1'b1;

    // mult -1 * 2
    issue(4'd1, 32'hFFFFFFFF, 32'h2, st);
    check("mult_stall", st, 1);
    run_busy("mult", 5, 32'h0, 32'h0);
    check("mult_hi", HI, 32'hFFFFFFFF);
    check("mult_lo", LO, 32'hFFFFFFFE);

    // multu 0xFFFFFFFF * 2
    issue(4'd2, 32'hFFFFFFFF, 32'h2, st);
    run_busy("multu", 5, 32'hFFFFFFFF, 32'hFFFFFFFE);
    check("multu_hi", HI, 32'h1);
    check("multu_lo", LO, 32'hFFFFFFFE);

    // div -7 / 2
    issue(4'd3, 32'hFFFFFFF9, 32'h2, st);
    check("div_stall", st, 1);
    run_busy("div", 32, 32'h1, 32'hFFFFFFFE);
    check("div_lo", LO, 32'hFFFFFFFD);
    check("div_hi", HI, 32'hFFFFFFFF);

    // divu 7 / 2
    issue(4'd4, 32'h7, 32'h2, st);
    run_busy("divu", 32, 32'hFFFFFFFF, 32'hFFFFFFFD);
    check("divu_lo", LO, 32'h3);
    check("divu_hi", HI, 32'h1);

    // signed overflow case
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, st);
    run_busy("divovf", 32, 32'h1, 32'h3);
    check("divovf_lo", LO, 32'h80000000);
    check("divovf_hi", HI, 32'h0);

    // mthi then divide by zero
    issue(4'd5, 32'h12345678, 32'h0, st);
    check("mthi_stall", st, 0);
    check("mthi_busy", busy, 0);
    check("mthi_hi", HI, 32'h12345678);
    issue(4'd4, 32'h5, 32'h0, st);
    run_busy("divz", 32, 32'h12345678, 32'h80000000);
    check("divz_hi", HI, 32'h12345678);
    check("divz_lo", LO, 32'h80000000);

    // nop, undefined code, and mult without start change nothing
    issue(4'd0, 32'hAAAA5555, 32'h3, st);
    issue(4'd13, 32'hAAAA5555, 32'h3, st);
    check("undef_stall", st, 0);
    @(negedge clk);
    MDUOp = 4'd1; A = 32'h9; B = 32'h9; start = 1'b0;
    #1 check("nostart_stall", stall, 0);
    @(negedge clk);
    MDUOp = 4'd0;
    check("nop_busy", busy, 0);
    check("nop_hi", HI, 32'h12345678);
    check("nop_lo", LO, 32'h80000000);

    // mtlo during busy cycle 2 of a mult is ignored
    issue(4'd1, 32'h00010000, 32'h00010000, st);
    @(negedge clk);
    MDUOp = 4'd6; A = 32'hDEADBEEF; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = 4'd0;
    run_busy("mtlo_ign", 3, 32'h12345678, 32'h80000000);
    check("mtlo_ign_hi", HI, 32'h1);
    check("mtlo_ign_lo", LO, 32'h0);

    // start on the completion edge is ignored; next cycle is accepted
    issue(4'd2, 32'h2, 32'h3, st);
    repeat (4) @(negedge clk);
    MDUOp = 4'd5; A = 32'hAAAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0; MDUOp = 4'd0;
    check("edge_busy", busy, 0);
    check("edge_hi", HI, 32'h0);
    check("edge_lo", LO, 32'h6);
    issue(4'd5, 32'h55, 32'h0, st);
    check("after_edge_hi", HI, 32'h55);

    // reset on busy cycle 10 of a divide
    issue(4'd3, 32'd100, 32'd7, st);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_hi", HI, 0);
    check("midrst_lo", LO, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("postrst_hi", HI, 0);
    check("postrst_lo", LO, 0);
    check("postrst_busy", busy, 0);
    issue(4'd5, 32'h7, 32'h0, st);
    check("postrst_mthi", HI, 32'h7);

    // multiply-accumulate
    issue(4'd6, 32'h5, 32'h0, st);
    issue(4'd5, 32'h0, 32'h0, st);
`ifdef MDU_MADD_EN
    issue(4'd7, 32'h3, 32'h4, st);
    check("madd_stall", st, 1);
    run_busy("madd", 5, 32'h0, 32'h5);
    check("madd_hi", HI, 32'h0);
    check("madd_lo", LO, 32'd17);
    issue(4'd9, 32'h3, 32'h4, st);
    run_busy("msub", 5, 32'h0, 32'd17);
    check("msub_hi", HI, 32'h0);
    check("msub_lo", LO, 32'h5);
    issue(4'd9, 32'h3, 32'h4, st);
    run_busy("msubneg", 5, 32'h0, 32'h5);
    check("msubneg_hi", HI, 32'hFFFFFFFF);
    check("msubneg_lo", LO, 32'hFFFFFFF9);
`else
    issue(4'd7, 32'h3, 32'h4, st);
    check("madd_off_stall", st, 0);
    check("madd_off_busy", busy, 0);
    check("madd_off_hi", HI, 32'h0);
    check("madd_off_lo", LO, 32'h5);
`endif

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 A  input  32  operand 1 (rs); dividend / multiplicand / mthi-mtlo source.
REQ-004 B  input  32  operand 2 (rt); divisor / multiplier.
REQ-005 MDUOp  input  4  0 nop, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 madd, 8 maddu, 9 msub, 10 msubu, 11-15 nop.
REQ-006 start  input  1  sampled with MDUOp; qualifies the operation for one cycle.
REQ-007 HI  output  32  HI register.
REQ-008 LO  output  32  LO register.
REQ-009 busy  output  1  registered; high while a mult/div is in progress.
REQ-010 stall  output  1  combinational: busy | (start & MDUOp is a multi-cycle op).

Function
REQ-011 States SHALL be IDLE, MUL, DIV; reset enters IDLE.
REQ-012 In IDLE, start with mult/multu/madd/maddu/msub/msubu SHALL latch operands, set busy next edge, enter MUL with counter 5.
REQ-013 MUL SHALL hold busy exactly 5 cycles; on the 5th edge HI:LO SHALL take the 64-bit result, busy SHALL drop, state SHALL return to IDLE.
REQ-014 mult SHALL use signed 32x32->64; multu unsigned; madd/maddu SHALL add the product to the HI:LO value at start; msub/msubu SHALL subtract it; arithmetic modulo 2^64.
REQ-015 In IDLE, start with div/divu SHALL latch operands, enter DIV, set busy for exactly 32 cycles, producing one quotient bit per cycle by restoring division on magnitudes.
REQ-016 On the final DIV edge LO SHALL take the quotient, HI the remainder; signed: quotient truncated toward zero, remainder sign of dividend.
REQ-017 Signed 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0x00000000.
REQ-018 Divisor zero SHALL still run 32 busy cycles and SHALL leave HI and LO unchanged.
REQ-019 mthi/mtlo with start in IDLE SHALL write A to HI/LO on that edge, busy unaffected.
REQ-020 start while busy (any op) SHALL be ignored; in-flight operation SHALL complete unaffected.
REQ-021 HI/LO SHALL be stable during busy, holding pre-operation values until the completion edge.
REQ-022 nop, undefined codes, or start=0 SHALL change no state.
REQ-023 start on the same edge busy falls SHALL be ignored (IDLE reached after that edge); a new op is accepted the following cycle.

Reset
REQ-024 rst_n low SHALL asynchronously force HI=0, LO=0, busy=0, state IDLE, counter 0, latched operands 0.
REQ-025 Reset mid-MUL or mid-DIV SHALL abort the operation with no HI/LO update after release.
REQ-026 Operation acceptance SHALL resume on the first rising edge with rst_n high.

Configuration
REQ-027 Macro MDU_MADD_EN defined: codes 7-10 SHALL behave per REQ-012..014.
REQ-028 MDU_MADD_EN undefined: codes 7-10 SHALL be treated as nop (no busy, no HI/LO change, stall=0), and accumulate/subtract logic SHALL be absent.

Verification
REQ-029 mult A=0xFFFFFFFF B=0x00000002 -> busy 5 cycles, then HI=0xFFFFFFFF LO=0xFFFFFFFE; multu same -> HI=0x00000001 LO=0xFFFFFFFE.
REQ-030 div A=0xFFFFFFF9 (-7) B=2 -> busy 32 cycles, then LO=0xFFFFFFFD HI=0xFFFFFFFF; divu 7/2 -> LO=3 HI=1.
REQ-031 mthi 0x12345678, then divu A=5 B=0 -> 32 busy cycles, HI stays 0x12345678, LO unchanged.
REQ-032 Start mult, on cycle 2 of busy issue mtlo 0xDEADBEEF -> ignored; final LO equals product low word.
REQ-033 Start div, pull rst_n low on busy cycle 10 -> HI=LO=0, busy=0 immediately; no update after release.
REQ-034 With MDU_MADD_EN: HI:LO=0:5, madd A=3 B=4 -> HI=0 LO=17; msub A=3 B=4 -> LO=5; without macro madd -> no busy, HI:LO unchanged.
